// File: rtl/odo_pkg.sv
// Shared odometry definitions: command widths, encoder resolution and quadrature
// state encoding used by the encoder emulator, the pulse counter and odometry.
package odo_pkg;

  localparam int PERIOD_W = 22;
  localparam int CPR      = 1024;

  // Values are the (A,B) pair, so A and B come straight off the state bits
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q10 = 2'b10,
    Q11 = 2'b11,
    Q01 = 2'b01
  } quad_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  function automatic quad_t quad_next(input quad_t q, input logic dir);
    quad_t n;
    case (q)
      Q00:     n = (dir == DIR_FWD) ? Q10 : Q01;
      Q10:     n = (dir == DIR_FWD) ? Q11 : Q00;
      Q11:     n = (dir == DIR_FWD) ? Q01 : Q10;
      default: n = (dir == DIR_FWD) ? Q00 : Q11;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_encoder_emulator_if.sv
// Command handshake and encoder outputs of the quadrature encoder emulator.
interface quad_encoder_emulator_if
  import odo_pkg::*;
#(
  parameter int PERIOD_W = odo_pkg::PERIOD_W,
  parameter int POS_W    = 32
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [PERIOD_W-1:0]     cmd_period;
  logic                    cmd_dir;
  logic                    enc_a;
  logic                    enc_b;
  logic                    enc_z;
  logic                    running;
  logic signed [POS_W-1:0] position;

  modport master (
    output cmd_valid, cmd_period, cmd_dir,
    input  cmd_ready, enc_a, enc_b, enc_z, running, position
  );

  modport slave (
    input  cmd_valid, cmd_period, cmd_dir,
    output cmd_ready, enc_a, enc_b, enc_z, running, position
  );
endinterface

// File: rtl/quad_step_timer.sv
// Step-rate generator: holds the active (clamped) period and emits a one-cycle
// strobe every period cycles while the period is nonzero.
module quad_step_timer
  import odo_pkg::*;
#(
  parameter int PERIOD_W = odo_pkg::PERIOD_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                load,
  input  logic [PERIOD_W-1:0] period,
  output logic                step,
  output logic                active
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  // A single-cycle period would make A and B change on consecutive edges with no settle time
  function automatic logic [PERIOD_W-1:0] clamp_period(input logic [PERIOD_W-1:0] p);
    return (p == ONE) ? PERIOD_W'(2) : p;
  endfunction

  logic [PERIOD_W-1:0] act_period;
  logic [PERIOD_W-1:0] count;

  assign active = (act_period != '0);
  assign step   = active && (count == act_period - ONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      act_period <= '0;
      count      <= '0;
    end else if (load) begin
      act_period <= clamp_period(period);
      count      <= '0;
    end else if (step) begin
      count <= '0;
    end else if (active) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: A/B/Z at a commanded step period and direction,
// with commands double-buffered so they only take effect on a step boundary.
module quad_encoder_emulator
  import odo_pkg::*;
#(
  parameter int PERIOD_W = odo_pkg::PERIOD_W,
  parameter int CPR      = odo_pkg::CPR,
  parameter int POS_W    = 32
) (
  input logic                    CLK,
  input logic                    RST,
  quad_encoder_emulator_if.slave bus
);

  localparam int                     SP_W    = $clog2(4 * CPR);
  localparam logic [SP_W-1:0]        SP_LAST = SP_W'(4 * CPR - 1);
  localparam logic [SP_W-1:0]        SP_ONE  = SP_W'(1);
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  logic [PERIOD_W-1:0]     sh_period;
  logic                    sh_dir;
  logic                    sh_full;
  logic                    act_dir;
  logic                    accept;
  logic                    load;
  logic                    step;
  logic                    active;
  quad_t                   q, q_next;
  logic [SP_W-1:0]         step_pos, step_pos_next;
  logic signed [POS_W-1:0] pos;
  logic                    z;

  assign accept = bus.cmd_valid && !sh_full;
  // While stopped there is no boundary to wait for; while running only a step edge may swap
  assign load   = sh_full && (!active || step);

  quad_step_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .load   (load),
    .period (sh_period),
    .step   (step),
    .active (active)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      sh_full <= 1'b0;
    end else if (accept) begin
      sh_full <= 1'b1;
    end else if (load) begin
      sh_full <= 1'b0;
    end
    if (accept) begin
      sh_period <= bus.cmd_period;
      sh_dir    <= bus.cmd_dir;
    end
    if (load) begin
      act_dir <= sh_dir;
    end
  end

  always_comb begin
    q_next        = q;
    step_pos_next = step_pos;
    if (step) begin
      q_next = quad_next(q, act_dir);
      if (act_dir == DIR_FWD) begin
        step_pos_next = (step_pos == SP_LAST) ? '0 : step_pos + SP_ONE;
      end else begin
        step_pos_next = (step_pos == '0) ? SP_LAST : step_pos - SP_ONE;
      end
    end
  end

  // The step at a load edge still uses the outgoing act_dir
  always_ff @(posedge CLK) begin
    if (RST) begin
      q        <= Q00;
      step_pos <= '0;
      pos      <= '0;
      z        <= 1'b0;
    end else begin
      q        <= q_next;
      step_pos <= step_pos_next;
      z        <= (step_pos_next == '0);
      if (step) begin
        pos <= (act_dir == DIR_FWD) ? pos + POS_ONE : pos - POS_ONE;
      end
    end
  end

  assign bus.cmd_ready = !sh_full;
  assign bus.enc_a     = q[1];
  assign bus.enc_b     = q[0];
  assign bus.enc_z     = z;
  assign bus.running   = active;
  assign bus.position  = pos;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for the quadrature encoder emulator (CPR reduced to 4 so the
// index wraps within a short run).
module tb_quad_encoder_emulator;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  quad_encoder_emulator_if #(.PERIOD_W(22), .POS_W(32)) bus ();

  quad_encoder_emulator #(.PERIOD_W(22), .CPR(4), .POS_W(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer a command for one edge; returns just after the acceptance edge
  task automatic send(input logic [21:0] p, input logic d);
    bus.cmd_valid  = 1'b1;
    bus.cmd_period = p;
    bus.cmd_dir    = d;
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
  endtask

  function automatic logic [31:0] ab();
    return {30'd0, bus.enc_a, bus.enc_b};
  endfunction

  initial begin
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_period = '0;
    bus.cmd_dir    = 1'b0;
    cycles(2);
    chk("rst_ab", ab(), 32'h0);
    chk("rst_z", {31'd0, bus.enc_z}, 32'd0);
    chk("rst_pos", bus.position, 32'd0);
    chk("rst_running", {31'd0, bus.running}, 32'd0);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    rst = 1'b0;
    cycles(1);
    chk("z_after_release", {31'd0, bus.enc_z}, 32'd1);

    // Forward at P=5 from stop
    send(22'd5, 1'b1);
    chk("t1_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
    chk("t1_not_running", {31'd0, bus.running}, 32'd0);
    cycles(1);
    chk("t1_running", {31'd0, bus.running}, 32'd1);
    chk("t1_ready_free", {31'd0, bus.cmd_ready}, 32'd1);
    cycles(4);
    chk("t1_pre_ab", ab(), 32'b00);
    chk("t1_pre_z", {31'd0, bus.enc_z}, 32'd1);
    cycles(1);
    chk("t1_s1_ab", ab(), 32'b10);
    chk("t1_s1_pos", bus.position, 32'd1);
    chk("t1_s1_z", {31'd0, bus.enc_z}, 32'd0);
    cycles(5);
    chk("t1_s2_ab", ab(), 32'b11);
    cycles(5);
    chk("t1_s3_ab", ab(), 32'b01);
    cycles(5);
    chk("t1_s4_ab", ab(), 32'b00);
    chk("t1_s4_pos", bus.position, 32'd4);

    // Reverse at P=3 queued while running at P=5
    send(22'd3, 1'b0);
    chk("t2_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
    cycles(3);
    chk("t2_still_busy", {31'd0, bus.cmd_ready}, 32'd0);
    chk("t2_hold_ab", ab(), 32'b00);
    cycles(1);
    chk("t2_boundary_fwd_ab", ab(), 32'b10);
    chk("t2_boundary_pos", bus.position, 32'd5);
    chk("t2_ready_free", {31'd0, bus.cmd_ready}, 32'd1);
    cycles(2);
    chk("t2_gap_ab", ab(), 32'b10);
    cycles(1);
    chk("t2_r1_ab", ab(), 32'b00);
    chk("t2_r1_pos", bus.position, 32'd4);
    cycles(3);
    chk("t2_r2_ab", ab(), 32'b01);
    cycles(3);
    chk("t2_r3_ab", ab(), 32'b11);
    chk("t2_r3_pos", bus.position, 32'd2);

    // Period 1 clamps to 2
    send(22'd1, 1'b1);
    cycles(2);
    chk("t3_load_step_ab", ab(), 32'b10);
    chk("t3_load_step_pos", bus.position, 32'd1);
    cycles(1);
    chk("t3_no_step_ab", ab(), 32'b10);
    cycles(1);
    chk("t3_step_ab", ab(), 32'b11);
    chk("t3_step_pos", bus.position, 32'd2);

    // Index pulse at step_pos wrap 15->0, then reverse 0->15
    cycles(27);
    chk("t4_pre_z", {31'd0, bus.enc_z}, 32'd0);
    cycles(1);
    chk("t4_z_on", {31'd0, bus.enc_z}, 32'd1);
    chk("t4_z_pos", bus.position, 32'd16);
    chk("t4_z_ab", ab(), 32'b00);
    cycles(1);
    chk("t4_z_on2", {31'd0, bus.enc_z}, 32'd1);
    cycles(1);
    chk("t4_z_off", {31'd0, bus.enc_z}, 32'd0);
    chk("t4_z_off_pos", bus.position, 32'd17);
    send(22'd2, 1'b0);
    cycles(1);
    chk("t4_boundary_pos", bus.position, 32'd18);
    cycles(4);
    chk("t4_rev_z_on", {31'd0, bus.enc_z}, 32'd1);
    chk("t4_rev_pos", bus.position, 32'd16);
    cycles(2);
    chk("t4_rev_z_off", {31'd0, bus.enc_z}, 32'd0);
    chk("t4_rev_wrap_pos", bus.position, 32'd15);
    chk("t4_rev_wrap_ab", ab(), 32'b01);

    // Stop with period 0, then restart at P=4
    send(22'd0, 1'b0);
    cycles(1);
    chk("t5_stop_running", {31'd0, bus.running}, 32'd0);
    chk("t5_stop_pos", bus.position, 32'd14);
    chk("t5_stop_ab", ab(), 32'b11);
    cycles(6);
    chk("t5_frozen_pos", bus.position, 32'd14);
    chk("t5_frozen_ab", ab(), 32'b11);
    send(22'd4, 1'b0);
    cycles(4);
    chk("t5_restart_wait_pos", bus.position, 32'd14);
    cycles(1);
    chk("t5_restart_pos", bus.position, 32'd13);
    chk("t5_restart_ab", ab(), 32'b10);
    chk("t5_restart_running", {31'd0, bus.running}, 32'd1);

    // Reset mid-run drops the pending shadow command
    send(22'd3, 1'b1);
    chk("t6_pending", {31'd0, bus.cmd_ready}, 32'd0);
    rst = 1'b1;
    cycles(1);
    chk("t6_rst_ab", ab(), 32'b00);
    chk("t6_rst_z", {31'd0, bus.enc_z}, 32'd0);
    chk("t6_rst_pos", bus.position, 32'd0);
    chk("t6_rst_running", {31'd0, bus.running}, 32'd0);
    chk("t6_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
    rst = 1'b0;
    cycles(1);
    chk("t6_release_z", {31'd0, bus.enc_z}, 32'd1);
    cycles(5);
    chk("t6_discarded_running", {31'd0, bus.running}, 32'd0);
    chk("t6_discarded_ab", ab(), 32'b00);

    // Reverse from zero: position wraps negative, index leaves step_pos 0
    send(22'd2, 1'b0);
    cycles(1);
    chk("t7_running", {31'd0, bus.running}, 32'd1);
    cycles(2);
    chk("t7_neg_pos", bus.position, 32'hFFFF_FFFF);
    chk("t7_neg_ab", ab(), 32'b01);
    chk("t7_neg_z", {31'd0, bus.enc_z}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
